spi_bridge_ctrl: RTL



---
 rtl/spi_bridge_pkg.sv | 9 +
 rtl/spi_byte_shifter.sv | 59 +++++
 rtl/spi_bridge_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the UART-to-SPI bridge: frame FSM states and parameter defaults.
package spi_bridge_pkg;
  localparam int CLK_DIV_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 2000000;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_WAIT_BYTE, S_SHIFT, S_TX_WAIT, S_CS_HOLD, S_CS_GAP
  } state_t;
endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: SCLK divider, full-duplex 8-bit shift, start/done handshake.
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] dout
);
  logic       active;
  logic [7:0] div;
  logic [2:0] bitn;
  logic [7:0] tx_sr;

  logic phase_end;
  assign phase_end = (div == 8'(CLK_DIV - 1));
  assign mosi      = tx_sr[7];
  // done coincides with the final falling edge so the byte takes exactly 16*CLK_DIV cycles
  assign done      = active && sclk && phase_end && (bitn == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      div    <= '0;
      bitn   <= '0;
      tx_sr  <= '0;
      sclk   <= 1'b0;
      dout   <= '0;
    end else if (start) begin
      active <= 1'b1;
      div    <= '0;
      bitn   <= '0;
      tx_sr  <= din;
      sclk   <= 1'b0;
    end else if (active) begin
      if (phase_end) begin
        div <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
          dout <= {dout[6:0], miso};
        end else begin
          sclk <= 1'b0;
          if (bitn == 3'd7) active <= 1'b0;
          else begin
            bitn  <= bitn + 3'd1;
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end else begin
        div <= div + 8'd1;
      end
    end
  end
endmodule

// File: rtl/spi_bridge_ctrl.sv
// UART-framed SPI bridge: length byte N, then N bytes shifted full-duplex with MISO echoed to UART TX.
module spi_bridge_ctrl
  import spi_bridge_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ack,
  output logic [7:0] tx_data,
  output logic       tx_ack,
  input  logic       tx_ready,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       busy
);
  localparam int TW = $clog2((TIMEOUT_CYC > 256) ? TIMEOUT_CYC : 256) + 1;

  state_t        state, state_d;
  logic [7:0]    cnt, cnt_d;
  logic [TW-1:0] tmr, tmr_d;
  logic          rx_ack_d, tx_ack_d, cs_n_d, start, done;
  logic [7:0]    tx_data_d, dout;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk(sys_clk), .rst_n(sys_rst_n), .start(start), .din(rx_data), .miso(spi_miso),
    .sclk(spi_sclk), .mosi(spi_mosi), .done(done), .dout(dout)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tmr      <= '0;
      rx_ack   <= 1'b0;
      tx_ack   <= 1'b0;
      tx_data  <= '0;
      spi_cs_n <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      tmr      <= tmr_d;
      rx_ack   <= rx_ack_d;
      tx_ack   <= tx_ack_d;
      tx_data  <= tx_data_d;
      spi_cs_n <= cs_n_d;
    end
  end

  // rx_ack is registered, so the byte being acked is still presented for one more
  // cycle; the !rx_ack guard stops that cycle from consuming it twice.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tmr_d     = tmr;
    rx_ack_d  = 1'b0;
    tx_ack_d  = 1'b0;
    tx_data_d = tx_data;
    cs_n_d    = spi_cs_n;
    start     = 1'b0;
    case (state)
      S_IDLE: if (rx_ready && !rx_ack) begin
        rx_ack_d = 1'b1;
        cnt_d    = rx_data;
        tmr_d    = '0;
        if (rx_data != 8'd0) begin
          cs_n_d  = 1'b0;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: if (tmr == TW'(CLK_DIV - 1)) begin
        tmr_d   = '0;
        state_d = S_WAIT_BYTE;
      end else tmr_d = tmr + TW'(1);
      S_WAIT_BYTE: if (rx_ready && !rx_ack) begin
        rx_ack_d = 1'b1;
        start    = 1'b1;
        tmr_d    = '0;
        state_d  = S_SHIFT;
      end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
        tmr_d   = '0;
        state_d = S_CS_HOLD;
      end else tmr_d = tmr + TW'(1);
      S_SHIFT: if (done) state_d = S_TX_WAIT;
      S_TX_WAIT: if (tx_ready) begin
        tx_ack_d  = 1'b1;
        tx_data_d = dout;
        tmr_d     = '0;
        if (cnt != 8'd0) cnt_d = cnt - 8'd1;
        state_d   = (cnt > 8'd1) ? S_WAIT_BYTE : S_CS_HOLD;
      end
      S_CS_HOLD: if (tmr == TW'(CLK_DIV - 1)) begin
        tmr_d   = '0;
        cs_n_d  = 1'b1;
        state_d = S_CS_GAP;
      end else tmr_d = tmr + TW'(1);
      S_CS_GAP: if (tmr == TW'(CLK_DIV - 1)) begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end else tmr_d = tmr + TW'(1);
      default: state_d = S_IDLE;
    endcase
  end
endmodule
